// File: rtl/exp_taylor_arb_pkg.sv
// Shared constants and the round-robin pick helper for the exp_taylor_arb slice.
package exp_arb_pkg;

  localparam int EXP_IN_W  = 12;
  localparam int EXP_OUT_W = 16;

  // Widest requester vector the pick helper handles; narrower users zero-extend.
  localparam int MAX_REQ = 16;
  localparam int REQ_IDW = 4;

  // One-hot grant for the first set bit at or above ptr, wrapping around.
  // Bits above the real requester count must be zero, which makes the
  // 16-way wrap equivalent to wrapping modulo the real count.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [REQ_IDW-1:0] ptr);
    logic [MAX_REQ-1:0] grant;
    logic [REQ_IDW-1:0] idx;
    logic               found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = ptr + REQ_IDW'(i);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/exp_taylor_arb_if.sv
// Request, exp-unit and response signals of exp_taylor_arb; slave = arbiter side.
interface exp_taylor_arb_if
  import exp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]          iReqValid;
  logic [NUM_REQ*EXP_IN_W-1:0] iReqData;
  logic [NUM_REQ-1:0]          oReqReady;
  logic [EXP_IN_W-1:0]         oExpData;
  logic                        oExpDataValid;
  logic [EXP_OUT_W-1:0]        iExpData;
  logic                        iExpDataValid;
  logic [EXP_OUT_W-1:0]        oRespData;
  logic                        oRespValid;
  logic [$clog2(NUM_REQ)-1:0]  oRespId;

  modport slave (
    input  iReqValid, iReqData, iExpData, iExpDataValid,
    output oReqReady, oExpData, oExpDataValid, oRespData, oRespValid, oRespId
  );

  modport master (
    output iReqValid, iReqData, iExpData, iExpDataValid,
    input  oReqReady, oExpData, oExpDataValid, oRespData, oRespValid, oRespId
  );

endinterface

// File: rtl/exp_taylor_arb_tag_fifo.sv
// Synchronous tag FIFO recording the owner of each in-flight exp operation.
module exp_arb_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       popData,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             wrEn;
  logic             rdEn;

  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign wrEn    = push && !full;
  assign rdEn    = pop && !empty;
  assign popData = mem[rdPtr];

  // Tag storage write port.
  // NOTE: the storage array is deliberately not reset; pointers and count say which entries are live.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= pushData;
  end

  // Pointer and occupancy bookkeeping; flush behaves like a reset of the queue.
  // NOTE: non-blocking assignments so every register updates from its pre-edge value.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= nextPtr(wrPtr);
      if (rdEn) rdPtr <= nextPtr(rdPtr);
      case ({wrEn, rdEn})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/exp_taylor_arb.sv
// Round-robin scheduler sharing one external exp unit between NUM_REQ requesters.
// Optional watchdog that flushes lost operations: define EXP_ARB_TIMEOUT_EN.
module exp_taylor_arb
  import exp_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ISSUE_GAP = 1,
  parameter int MAX_OUT   = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rst,
  exp_taylor_arb_if.slave     bus,
  output logic                oBusy,
  output logic                oErr
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_OUT) + 1;
  localparam int GW  = $clog2(ISSUE_GAP) + 1;

  logic [IDW-1:0]       ptr;
  logic [GW-1:0]        gapCnt;
  logic [MAX_REQ-1:0]   pick;
  logic [IDW-1:0]       pickIdx;
  logic                 pickAny;
  logic                 issueOk;
  logic                 xfer;
  logic [EXP_IN_W-1:0]  selData;
  logic [NUM_REQ-1:0]   grant;
  logic [CW-1:0]        fifoCount;
  logic                 fifoEmpty;
  logic                 fifoFull;
  logic [IDW-1:0]       popTag;
  logic                 popEn;
  logic                 spurious;
  logic                 timeoutHit;

  logic [EXP_IN_W-1:0]  expData;
  logic                 expDataValid;
  logic [EXP_OUT_W-1:0] respData;
  logic                 respValid;
  logic [IDW-1:0]       respId;
  logic                 errFlag;

  assign pick = rr_pick(MAX_REQ'(bus.iReqValid), REQ_IDW'(ptr));

  // Turn the padded one-hot pick into a requester index.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pickIdx = '0;
    pickAny = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (pick[k]) begin
        pickIdx = IDW'(k);
        pickAny = 1'b1;
      end
    end
  end

  assign issueOk  = !rst && (gapCnt == '0) && (fifoCount < CW'(MAX_OUT)) && !timeoutHit;
  assign xfer     = issueOk && pickAny;
  assign grant    = xfer ? (NUM_REQ'(1) << pickIdx) : '0;
  assign selData  = bus.iReqData[pickIdx*EXP_IN_W +: EXP_IN_W];
  assign popEn    = bus.iExpDataValid && !fifoEmpty && !rst;
  assign spurious = bus.iExpDataValid && fifoEmpty;

  exp_arb_tag_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUT)
  ) u_tagFifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (timeoutHit),
    .push     (xfer),
    .pushData (pickIdx),
    .pop      (popEn),
    .popData  (popTag),
    .empty    (fifoEmpty),
    .full     (fifoFull),
    .count    (fifoCount)
  );

`ifdef EXP_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdCnt;

  assign timeoutHit = (fifoCount != '0) && !bus.iExpDataValid && (wdCnt == WD_W'(TIMEOUT - 1));

  // Watchdog: count silent cycles while operations are outstanding.
  always_ff @(posedge clk) begin
    if (rst || bus.iExpDataValid || (fifoCount == '0) || timeoutHit) wdCnt <= '0;
    else                                                            wdCnt <= wdCnt + WD_W'(1);
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // Issue side: register the granted operand, advance the pointer, arm the gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      gapCnt       <= '0;
      expData      <= '0;
      expDataValid <= 1'b0;
    end else begin
      expDataValid <= xfer;
      if (xfer) begin
        expData <= selData;
        ptr     <= (pickIdx == IDW'(NUM_REQ - 1)) ? '0 : pickIdx + IDW'(1);
        gapCnt  <= GW'(ISSUE_GAP - 1);
      end else if (gapCnt != '0) begin
        gapCnt <= gapCnt - GW'(1);
      end
    end
  end

  // Response side: tag each result with its owner; results with no owner raise the error.
  always_ff @(posedge clk) begin
    if (rst) begin
      respData  <= '0;
      respValid <= 1'b0;
      respId    <= '0;
      errFlag   <= 1'b0;
    end else begin
      respValid <= popEn;
      if (popEn) begin
        respData <= bus.iExpData;
        respId   <= popTag;
      end
      if (spurious || timeoutHit) errFlag <= 1'b1;
    end
  end

  assign bus.oReqReady     = grant;
  assign bus.oExpData      = expData;
  assign bus.oExpDataValid = expDataValid;
  assign bus.oRespData     = respData;
  assign bus.oRespValid    = respValid;
  assign bus.oRespId       = respId;
  assign oBusy             = (fifoCount != '0);
  assign oErr              = errFlag;

endmodule

// File: tb/tb_exp_taylor_arb.sv
// Scoreboard bench for exp_taylor_arb: instance A (gap 1, 4 outstanding), instance B (gap 4, 2 outstanding).
module tb_exp_taylor_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_taylor_arb_if #(.NUM_REQ(4)) ifA ();
  exp_taylor_arb_if #(.NUM_REQ(4)) ifB ();
  logic busyA, errA, busyB, errB;

  exp_taylor_arb #(.NUM_REQ(4), .ISSUE_GAP(1), .MAX_OUT(4), .TIMEOUT(64)) dutA (
    .clk(clk), .rst(rst), .bus(ifA.slave), .oBusy(busyA), .oErr(errA));
  exp_taylor_arb #(.NUM_REQ(4), .ISSUE_GAP(4), .MAX_OUT(2), .TIMEOUT(64)) dutB (
    .clk(clk), .rst(rst), .bus(ifB.slave), .oBusy(busyB), .oErr(errB));

  function automatic logic [15:0] respFn(input logic [11:0] op);
    return {4'hA, op};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- exp unit models ----------------
  logic [15:0] mAData = '0, spAData = '0, mBData = '0, fixValA = '0;
  logic        mAValid = 1'b0, spAValid = 1'b0, mBValid = 1'b0;
  bit          holdA = 1'b0, holdB = 1'b0, fixA = 1'b0;
  int          latA = 1, latB = 0;
  logic [11:0] pendOpA[$], pendOpB[$];
  int          pendTA[$], pendTB[$];

  assign ifA.iExpDataValid = mAValid | spAValid;
  assign ifA.iExpData      = spAValid ? spAData : mAData;
  assign ifB.iExpDataValid = mBValid;
  assign ifB.iExpData      = mBData;

  always @(negedge clk) begin
    if (ifA.oExpDataValid) begin pendOpA.push_back(ifA.oExpData); pendTA.push_back(cyc); end
    if (ifB.oExpDataValid) begin pendOpB.push_back(ifB.oExpData); pendTB.push_back(cyc); end
  end

  always @(posedge clk) begin
    #1;
    mAValid = 1'b0;
    mBValid = 1'b0;
    if (!holdA && pendOpA.size() > 0 && cyc >= pendTA[0] + latA) begin
      mAData  = fixA ? fixValA : respFn(pendOpA[0]);
      mAValid = 1'b1;
      void'(pendOpA.pop_front());
      void'(pendTA.pop_front());
    end
    if (!holdB && pendOpB.size() > 0 && cyc >= pendTB[0] + latB) begin
      mBData  = respFn(pendOpB[0]);
      mBValid = 1'b1;
      void'(pendOpB.pop_front());
      void'(pendTB.pop_front());
    end
  end

  // ---------------- scoreboard ----------------
  logic [11:0] issQA[$], issQB[$];
  logic [17:0] rspQA[$], rspQB[$];   // {id, data}
  bit          gapChkB = 1'b0;
  int          lastB = -1;

  always @(negedge clk) begin
    if (ifA.oExpDataValid) begin
      if (issQA.size() == 0) begin
        checks++; errors++;
        $display("FAIL issA_extra: got operand %0d, expected no issue", ifA.oExpData);
      end else check("issA_data", 32'(ifA.oExpData), 32'(issQA.pop_front()));
    end
    if (ifA.oRespValid) begin
      if (rspQA.size() == 0) begin
        checks++; errors++;
        $display("FAIL rspA_extra: got id %0d data %0h, expected no response", ifA.oRespId, ifA.oRespData);
      end else check("rspA", 32'({ifA.oRespId, ifA.oRespData}), 32'(rspQA.pop_front()));
    end
    if (ifB.oExpDataValid) begin
      if (gapChkB && lastB >= 0) check("gapB", 32'(cyc - lastB), 32'd4);
      lastB = cyc;
      if (issQB.size() == 0) begin
        checks++; errors++;
        $display("FAIL issB_extra: got operand %0d, expected no issue", ifB.oExpData);
      end else check("issB_data", 32'(ifB.oExpData), 32'(issQB.pop_front()));
    end
    if (ifB.oRespValid) begin
      if (rspQB.size() == 0) begin
        checks++; errors++;
        $display("FAIL rspB_extra: got id %0d data %0h, expected no response", ifB.oRespId, ifB.oRespData);
      end else check("rspB", 32'({ifB.oRespId, ifB.oRespData}), 32'(rspQB.pop_front()));
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst = 1'b1;
    ifA.iReqValid = '0;
    ifB.iReqValid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int g = 0;
    while ((issQA.size() + rspQA.size() + issQB.size() + rspQB.size()) != 0 && g < budget) begin
      @(posedge clk);
      g++;
    end
    #2;
    check(name, 32'(issQA.size() + rspQA.size() + issQB.size() + rspQB.size()), 32'd0);
  endtask

  task automatic waitExpValidA(input int budget);
    int g = 0;
    while (!ifA.iExpDataValid && g < budget) begin step(); g++; end
    check("expValidA_seen", 32'(ifA.iExpDataValid), 32'd1);
  endtask

  task automatic waitExpValidB(input int budget);
    int g = 0;
    while (!ifB.iExpDataValid && g < budget) begin step(); g++; end
    check("expValidB_seen", 32'(ifB.iExpDataValid), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int g;
    ifA.iReqValid = 4'hF;
    ifA.iReqData  = '0;
    ifB.iReqValid = 4'b0100;
    ifB.iReqData  = '0;

    // Reset state: no grant while rst is high, all outputs zero.
    repeat (2) @(posedge clk);
    #2;
    check("rst_readyA", 32'(ifA.oReqReady), 32'd0);
    check("rst_readyB", 32'(ifB.oReqReady), 32'd0);
    check("rst_outsA", 32'({ifA.oExpDataValid, ifA.oRespValid, busyA, errA}), 32'd0);
    check("rst_dataA", 32'({ifA.oExpData, ifA.oRespData, ifA.oRespId}), 32'd0);
    check("rst_outsB", 32'({ifB.oExpDataValid, ifB.oRespValid, busyB, errB}), 32'd0);
    ifA.iReqValid = '0;
    ifB.iReqValid = '0;
    rst = 1'b0;
    step();

    // Single request from req0.
    fixA = 1'b1; fixValA = 16'h1234; latA = 1;
    ifA.iReqData[11:0] = 12'd384;
    ifA.iReqValid      = 4'b0001;
    #1;
    check("single_ready", 32'(ifA.oReqReady), 32'b0001);
    issQA.push_back(12'd384);
    rspQA.push_back({2'd0, 16'h1234});
    step();
    ifA.iReqValid = '0;
    check("single_issue", 32'({ifA.oExpDataValid, ifA.oExpData}), 32'({1'b1, 12'd384}));
    check("single_busy", 32'(busyA), 32'd1);
    step();
    check("single_pulse", 32'(ifA.oExpDataValid), 32'd0);
    drain("single_drain", 50);
    fixA = 1'b0;

    // Contention: all four valid, latency 3, expect grants 0,1,2,3,0,...
    doReset();
    latA = 3;
    ifA.iReqData  = {12'd739, 12'd738, 12'd737, 12'd736};
    ifA.iReqValid = 4'hF;
    n = 0; g = 0;
    while (n < 8 && g < 200) begin
      #1;
      if (ifA.oReqReady != '0) begin
        check("rr_grant", 32'(ifA.oReqReady), 32'(4'b0001 << (n % 4)));
        issQA.push_back(12'(736 + n % 4));
        rspQA.push_back({2'(n % 4), respFn(12'(736 + n % 4))});
        n++;
      end
      step();
      g++;
    end
    ifA.iReqValid = '0;
    check("rr_count", 32'(n), 32'd8);
    drain("rr_drain", 100);

    // Outstanding limit on A (4): results withheld, exactly 4 issues.
    holdA = 1'b1; latA = 0;
    ifA.iReqData  = {12'd103, 12'd102, 12'd101, 12'd100};
    ifA.iReqValid = 4'hF;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ifA.oReqReady != '0) begin
        issQA.push_back(12'(100 + n % 4));
        rspQA.push_back({2'(n % 4), respFn(12'(100 + n % 4))});
        n++;
      end
      step();
    end
    check("lim_count", 32'(n), 32'd4);
    check("lim_ready", 32'(ifA.oReqReady), 32'd0);
    check("lim_busy", 32'(busyA), 32'd1);
    holdA = 1'b0;
    waitExpValidA(10);
    check("lim_popcycle_ready", 32'(ifA.oReqReady), 32'd0);
    step();
    check("lim_after_pop_ready", 32'(ifA.oReqReady), 32'b0001);
    ifA.iReqValid = '0;
    drain("lim_drain", 50);

    // Spurious result with the FIFO empty.
    spAData  = 16'hBEEF;
    spAValid = 1'b1;
    step();
    spAValid = 1'b0;
    check("spur_err", 32'(errA), 32'd1);
    check("spur_resp", 32'(ifA.oRespValid), 32'd0);
    step();

    // Reset with three operations in flight.
    doReset();
    check("rst_clears_err", 32'(errA), 32'd0);
    holdA = 1'b1;
    ifA.iReqData  = {12'd0, 12'd202, 12'd201, 12'd200};
    ifA.iReqValid = 4'b0111;
    n = 0; g = 0;
    while (n < 3 && g < 20) begin
      #1;
      if (ifA.oReqReady != '0) begin issQA.push_back(12'(200 + n)); n++; end
      step();
      g++;
    end
    ifA.iReqValid = '0;
    check("flight_busy", 32'(busyA), 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_outs", 32'({ifA.oExpDataValid, ifA.oRespValid, busyA, errA}), 32'd0);
    check("mid_rst_ready", 32'(ifA.oReqReady), 32'd0);
    rst = 1'b0;
    holdA = 1'b0;
    repeat (10) step();
    check("late_results_err", 32'(errA), 32'd1);
    check("late_results_busy", 32'(busyA), 32'd0);

`ifdef EXP_ARB_TIMEOUT_EN
    // Watchdog: one lost operation is flushed after 64 silent cycles.
    doReset();
    holdA = 1'b1;
    ifA.iReqData[11:0] = 12'd5;
    ifA.iReqValid      = 4'b0001;
    #1;
    check("to_ready", 32'(ifA.oReqReady), 32'b0001);
    issQA.push_back(12'd5);
    step();
    ifA.iReqValid = '0;
    repeat (62) step();
    check("to_before", 32'({errA, busyA}), 32'b01);
    step();
    check("to_hit", 32'({errA, busyA}), 32'b10);
    pendOpA.delete();
    pendTA.delete();
    holdA = 1'b0;
    ifA.iReqValid = 4'b0010;
    #1;
    check("to_resume", 32'(ifA.oReqReady), 32'b0010);
    ifA.iReqValid = '0;
    step();
`endif

    // Issue gap on B (gap 4): req2 continuously, pulses every 4 cycles.
    ifB.iReqData  = {12'd0, 12'd2050, 12'd0, 12'd0};
    ifB.iReqValid = 4'b0100;
    gapChkB = 1'b1;
    lastB   = -1;
    n = 0; g = 0;
    while (n < 4 && g < 100) begin
      #1;
      if (ifB.oReqReady != '0) begin
        check("gap_grant", 32'(ifB.oReqReady), 32'b0100);
        issQB.push_back(12'd2050);
        rspQB.push_back({2'd2, respFn(12'd2050)});
        n++;
      end
      step();
      g++;
    end
    ifB.iReqValid = '0;
    check("gap_count", 32'(n), 32'd4);
    drain("gap_drain", 50);
    gapChkB = 1'b0;

    // Outstanding limit on B (2) with same-cycle pop.
    holdB = 1'b1;
    ifB.iReqData  = {12'd0, 12'd1000, 12'd0, 12'd0};
    ifB.iReqValid = 4'b0100;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (ifB.oReqReady != '0) begin
        issQB.push_back(12'd1000);
        rspQB.push_back({2'd2, respFn(12'd1000)});
        n++;
      end
      step();
    end
    check("limB_count", 32'(n), 32'd2);
    check("limB_ready", 32'(ifB.oReqReady), 32'd0);
    holdB = 1'b0;
    waitExpValidB(10);
    check("limB_popcycle_ready", 32'(ifB.oReqReady), 32'd0);
    step();
    check("limB_after_pop_ready", 32'(ifB.oReqReady), 32'b0100);
    ifB.iReqValid = '0;
    drain("limB_drain", 50);
    check("final_errB", 32'(errB), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
